reg_file_dump_load_engine: RTL and testbench

//  Initiator side of the Register_File port interface: drives write and read-port-1 to bulk-load
//  a register range from an input stream, or bulk-dump a range to an output stream.

---
 rtl/reg_file_dump_load_engine.sv | 119 +++++++++++
 tb/tb_reg_file_dump_load_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump_load_engine.sv
// Register-file bulk loader/dumper: owns the regfile write and read-port-1 while busy,
// streaming a register range in (load) or out (dump) over valid/ready handshakes.
module reg_file_dump_load_engine #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] first_reg_i,
  input  logic [ADDR_W-1:0] last_reg_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              Reg_Write_o,
  output logic [ADDR_W-1:0] Write_Register_o,
  output logic [N-1:0]      Write_Data_o,
  output logic [ADDR_W-1:0] Read_Register_1_o,
  input  logic [N-1:0]      Read_Data_1_i,
  input  logic [N-1:0]      load_data_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic [N-1:0]      dump_data_o,
  output logic [ADDR_W-1:0] dump_reg_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i
);

  typedef enum logic [1:0] {StIdle, StDump, StLoad, StDone} state_e;

  state_e            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;
  logic              last_hit;
  logic              error;
  logic              dump_valid;
  logic [N-1:0]      dump_data;
  logic [ADDR_W-1:0] dump_reg;

  logic load_accept;
  logic dump_fire;
  logic dump_capture;

  always_comb begin
    load_ready_o      = (state == StLoad) && !abort_i && !reset;
    load_accept       = load_ready_o && load_valid_i;
    // r0 is hard-wired zero: the word is consumed but never written
    Reg_Write_o       = load_accept && (cur != '0);
    Write_Register_o  = load_accept ? cur : '0;
    Write_Data_o      = load_accept ? load_data_i : '0;
    Read_Register_1_o = (state == StDump) ? cur : '0;
    busy_o            = (state == StDump) || (state == StLoad);
    done_o            = (state == StDone);
    error_o           = error;
    dump_valid_o      = dump_valid;
    dump_data_o       = dump_data;
    dump_reg_o        = dump_reg;
    dump_fire         = dump_valid && dump_ready_i;
    dump_capture      = (!dump_valid || dump_ready_i) && !last_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      cur        <= '0;
      last       <= '0;
      last_hit   <= 1'b0;
      error      <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_reg   <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        StIdle: begin
          if (start_i) begin
            if (first_reg_i <= last_reg_i) begin
              cur      <= first_reg_i;
              last     <= last_reg_i;
              last_hit <= 1'b0;
              state    <= mode_i ? StLoad : StDump;
            end else begin
              error <= 1'b1;
            end
          end
        end
        StDump: begin
          if (abort_i) begin
            dump_valid <= 1'b0;
            state      <= StIdle;
          end else if (dump_capture) begin
            dump_data  <= Read_Data_1_i;
            dump_reg   <= cur;
            dump_valid <= 1'b1;
            // stop flag instead of incrementing keeps cur from wrapping at the top register
            if (cur == last) last_hit <= 1'b1;
            else             cur      <= cur + 1'b1;
          end else if (dump_fire) begin
            dump_valid <= 1'b0;
            state      <= StDone;
          end
        end
        StLoad: begin
          if (abort_i) begin
            state <= StIdle;
          end else if (load_accept) begin
            if (cur == last) state <= StDone;
            else             cur   <= cur + 1'b1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump_load_engine.sv
// Scoreboard bench for reg_file_dump_load_engine: expected regfile writes and dump words are
// queued by the stimulus and popped by a negedge monitor whenever the DUT presents them.
module tb_reg_file_dump_load_engine;
  localparam int N = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i, mode_i, abort_i;
  logic [AW-1:0] first_reg_i, last_reg_i;
  logic          busy_o, done_o, error_o;
  logic          Reg_Write_o;
  logic [AW-1:0] Write_Register_o, Read_Register_1_o, dump_reg_o;
  logic [N-1:0]  Write_Data_o, Read_Data_1_i, load_data_i, dump_data_o;
  logic          load_valid_i, load_ready_o, dump_valid_o, dump_ready_i;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int error_count = 0;
  int dump_pops = 0;

  logic [AW+N-1:0] exp_wr[$];
  logic [AW+N-1:0] exp_dump[$];

  bit [N-1:0] rf [32];
  bit [31:0]  written;

  always #5 clk = ~clk;

  reg_file_dump_load_engine #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
    .first_reg_i(first_reg_i), .last_reg_i(last_reg_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o),
    .Write_Data_o(Write_Data_o), .Read_Register_1_o(Read_Register_1_o),
    .Read_Data_1_i(Read_Data_1_i), .load_data_i(load_data_i), .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o), .dump_data_o(dump_data_o), .dump_reg_o(dump_reg_o),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i)
  );

  // Register file model: r0 reads zero, untouched registers read 0xA500_00<idx>
  always @(posedge clk) begin
    if (Reg_Write_o) begin
      rf[Write_Register_o]      <= Write_Data_o;
      written[Write_Register_o] <= 1'b1;
    end
  end

  always_comb begin
    Read_Data_1_i = '0;
    if (Read_Register_1_o != '0)
      Read_Data_1_i = written[Read_Register_1_o] ? rf[Read_Register_1_o]
                                                  : (32'hA500_0000 | 32'(Read_Register_1_o));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on regfile writes and dump handshakes
  always @(negedge clk) begin
    if (done_o) done_count++;
    if (error_o) error_count++;
    if (Reg_Write_o) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=%0h expected none", Write_Register_o,
                 Write_Data_o);
      end else begin
        logic [AW+N-1:0] e;
        e = exp_wr.pop_front();
        if ({Write_Register_o, Write_Data_o} !== e) begin
          errors++;
          $display("FAIL write: got r%0d=%0h expected r%0d=%0h", Write_Register_o,
                   Write_Data_o, e[AW+N-1:N], e[N-1:0]);
        end
      end
    end
    if (dump_valid_o && dump_ready_i) begin
      checks++;
      dump_pops++;
      if (exp_dump.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dump: got r%0d=%0h expected none", dump_reg_o, dump_data_o);
      end else begin
        logic [AW+N-1:0] e;
        e = exp_dump.pop_front();
        if ({dump_reg_o, dump_data_o} !== e) begin
          errors++;
          $display("FAIL dump: got r%0d=%0h expected r%0d=%0h", dump_reg_o, dump_data_o,
                   e[AW+N-1:N], e[N-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic mode, input int first, input int last);
    start_i     = 1'b1;
    mode_i      = mode;
    first_reg_i = AW'(first);
    last_reg_i  = AW'(last);
    tick();
    start_i = 1'b0;
  endtask

  task automatic load_word(input logic [N-1:0] data, input int gap);
    bit ok;
    ok = 1'b0;
    load_valid_i = 1'b0;
    repeat (gap) tick();
    load_valid_i = 1'b1;
    load_data_i  = data;
    for (int i = 0; i < 20; i++) begin
      if (load_ready_o) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    load_valid_i = 1'b0;
    chk("load_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input int max, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
    tick();
  endtask

  function automatic logic [AW+N-1:0] ent(input int r, input logic [N-1:0] d);
    return {AW'(r), d};
  endfunction

  initial begin
    int d0, p0;
    logic [N-1:0] v;
    reset = 1'b1; start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
    first_reg_i = '0; last_reg_i = '0; load_data_i = '0; load_valid_i = 1'b0;
    dump_ready_i = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'({busy_o, done_o, error_o, Reg_Write_o, load_ready_o, dump_valid_o,
                              dump_reg_o, Read_Register_1_o}), 64'd0);
    reset = 1'b0;
    tick();

    // 1: load r2..r4 with gaps, then read back
    d0 = done_count;
    exp_wr.push_back(ent(2, 7));
    exp_wr.push_back(ent(3, 20));
    exp_wr.push_back(ent(4, 6));
    start_op(1'b1, 2, 4);
    chk("load_busy", 64'(busy_o), 64'd1);
    load_word(32'd7, 0);
    load_word(32'd20, 2);
    load_word(32'd6, 1);
    wait_done(10, "load1_done");
    repeat (3) tick();
    chk("load1_done_once", 64'(done_count - d0), 64'd1);
    chk("load1_writes_left", 64'(exp_wr.size()), 64'd0);
    dump_ready_i = 1'b1;
    exp_dump.push_back(ent(2, 7));
    exp_dump.push_back(ent(3, 20));
    exp_dump.push_back(ent(4, 6));
    start_op(1'b0, 2, 4);
    wait_done(20, "readback_done");

    // 2: full dump 0..31
    d0 = done_count;
    p0 = dump_pops;
    for (int i = 0; i < 32; i++) begin
      if (i == 0)      v = 32'd0;
      else if (i == 2) v = 32'd7;
      else if (i == 3) v = 32'd20;
      else if (i == 4) v = 32'd6;
      else             v = 32'hA500_0000 | 32'(i);
      exp_dump.push_back(ent(i, v));
    end
    start_op(1'b0, 0, 31);
    wait_done(60, "dump_all_done");
    repeat (3) tick();
    chk("dump_all_words", 64'(dump_pops - p0), 64'd32);
    chk("dump_all_done_once", 64'(done_count - d0), 64'd1);
    chk("dump_all_queue", 64'(exp_dump.size()), 64'd0);

    // 3: single-word dump held under backpressure
    dump_ready_i = 1'b0;
    exp_dump.push_back(ent(25, 32'hA500_0019));
    start_op(1'b0, 25, 25);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (dump_valid_o) begin
          seen = 1'b1;
          break;
        end
      end
      chk("dump25_valid_timeout", 64'(seen), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dump25_hold", 64'({dump_valid_o, dump_reg_o, dump_data_o}),
          64'({1'b1, 5'd25, 32'hA500_0019}));
    end
    @(posedge clk);
    #1;
    dump_ready_i = 1'b1;
    wait_done(10, "dump25_done");
    chk("dump25_queue", 64'(exp_dump.size()), 64'd0);

    // 4: rejected range
    d0 = error_count;
    start_op(1'b0, 5, 3);
    chk("err_pulse", 64'({error_o, busy_o}), 64'b10);
    tick();
    chk("err_clear", 64'({error_o, busy_o}), 64'b00);
    tick();
    chk("err_once", 64'(error_count - d0), 64'd1);

    // 5: load r0..r1 (r0 not written), read back, then abort a dump
    exp_wr.push_back(ent(1, 78));
    start_op(1'b1, 0, 1);
    load_word(32'd3, 0);
    load_word(32'd78, 1);
    wait_done(10, "load01_done");
    exp_dump.push_back(ent(0, 0));
    exp_dump.push_back(ent(1, 78));
    start_op(1'b0, 0, 1);
    wait_done(20, "dump01_done");
    d0 = done_count;
    dump_ready_i = 1'b0;
    start_op(1'b0, 10, 20);
    repeat (3) tick();
    chk("pre_abort_valid", 64'({busy_o, dump_valid_o}), 64'b11);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_idle", 64'({busy_o, dump_valid_o, load_ready_o}), 64'd0);
    repeat (4) tick();
    chk("abort_no_done", 64'(done_count - d0), 64'd0);
    dump_ready_i = 1'b1;

    // 6: reset mid-load
    exp_wr.push_back(ent(6, 100));
    exp_wr.push_back(ent(7, 101));
    start_op(1'b1, 6, 9);
    load_word(32'd100, 0);
    load_word(32'd101, 0);
    load_valid_i = 1'b1;
    load_data_i  = 32'd102;
    reset        = 1'b1;
    tick();
    chk("reset_mid_load", 64'({busy_o, done_o, error_o, Reg_Write_o, load_ready_o, dump_valid_o,
                               dump_reg_o, Read_Register_1_o, Write_Register_o}), 64'd0);
    chk("reset_mid_data", 64'({Write_Data_o, dump_data_o}), 64'd0);
    reset = 1'b0;
    load_data_i = 32'd103;
    repeat (4) tick();
    load_valid_i = 1'b0;
    chk("post_reset_idle", 64'({busy_o, load_ready_o}), 64'd0);
    chk("writes_left", 64'(exp_wr.size()), 64'd0);
    chk("dumps_left", 64'(exp_dump.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
